reproductor_nota: RTL and testbench

REPRODUCTOR_NOTA -- requirements
Module: reproductor_nota

---
 rtl/pkg_musica.sv | 110 +++++++++++
 rtl/divisor_tono.sv | 43 ++++
 rtl/reproductor_nota.sv | 155 +++++++++++++++
 tb/tb_reproductor_nota.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_musica.sv
// pkg_musica
// Shared musical definitions for the note player and the song sequencer:
//   - note-code constants (0 = rest, 1..12 = C4..B4 chromatic, 13..15 = rest)
//   - FSM state encoding used by reproductor_nota
//   - the 25-entry song ROM contents
//   - the half-period function used to build the pitch table from CLK_HZ
package pkg_musica;

  localparam logic [3:0] NOTA_SILENCIO = 4'd0;
  localparam logic [3:0] NOTA_C4       = 4'd1;
  localparam logic [3:0] NOTA_CS4      = 4'd2;
  localparam logic [3:0] NOTA_D4       = 4'd3;
  localparam logic [3:0] NOTA_DS4      = 4'd4;
  localparam logic [3:0] NOTA_E4       = 4'd5;
  localparam logic [3:0] NOTA_F4       = 4'd6;
  localparam logic [3:0] NOTA_FS4      = 4'd7;
  localparam logic [3:0] NOTA_G4       = 4'd8;
  localparam logic [3:0] NOTA_GS4      = 4'd9;
  localparam logic [3:0] NOTA_A4       = 4'd10;
  localparam logic [3:0] NOTA_AS4      = 4'd11;
  localparam logic [3:0] NOTA_B4       = 4'd12;

  // Highest valid song step; anything above plays as a rest.
  localparam logic [4:0] DIR_MAX = 5'd24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PLAY  = 2'd2,
    ST_GAP   = 2'd3
  } estado_t;

  // True for codes that carry a pitch; everything else is silence.
  function automatic logic es_tono(input logic [3:0] codigo);
    return (codigo >= NOTA_C4) && (codigo <= NOTA_B4);
  endfunction

  // Song ROM, 25 steps. Out-of-range steps return a rest.
  function automatic logic [3:0] nota_cancion(input logic [4:0] dir);
    logic [3:0] nota;
    case (dir)
      5'd0:    nota = NOTA_C4;
      5'd1:    nota = NOTA_C4;
      5'd2:    nota = NOTA_G4;
      5'd3:    nota = NOTA_A4;
      5'd4:    nota = NOTA_C4;
      5'd5:    nota = NOTA_SILENCIO;
      5'd6:    nota = NOTA_G4;
      5'd7:    nota = NOTA_F4;
      5'd8:    nota = NOTA_F4;
      5'd9:    nota = NOTA_E4;
      5'd10:   nota = NOTA_E4;
      5'd11:   nota = NOTA_D4;
      5'd12:   nota = NOTA_D4;
      5'd13:   nota = NOTA_C4;
      5'd14:   nota = NOTA_G4;
      5'd15:   nota = NOTA_G4;
      5'd16:   nota = NOTA_F4;
      5'd17:   nota = NOTA_F4;
      5'd18:   nota = NOTA_E4;
      5'd19:   nota = NOTA_E4;
      5'd20:   nota = NOTA_D4;
      5'd21:   nota = NOTA_SILENCIO;
      5'd22:   nota = NOTA_B4;
      5'd23:   nota = NOTA_AS4;
      5'd24:   nota = NOTA_A4;
      default: nota = NOTA_SILENCIO;
    endcase
    return nota;
  endfunction

  // Half-period in clock cycles: round(clk_hz / (2*f)). Frequencies are the
  // usual two-decimal equal-tempered values (A4 = 440 Hz) held in centihertz,
  // so H = round(clk_hz*50 / f_cHz). Intended for elaboration-time use only;
  // the result is clamped to 1..65535 for pitched codes and 0 for rests.
  function automatic logic [15:0] calc_medio_periodo(input longint unsigned clk_hz,
                                                     input logic [3:0] codigo);
    longint unsigned f_chz;
    longint unsigned q;
    case (codigo)
      NOTA_C4:  f_chz = 64'd26163;
      NOTA_CS4: f_chz = 64'd27718;
      NOTA_D4:  f_chz = 64'd29366;
      NOTA_DS4: f_chz = 64'd31113;
      NOTA_E4:  f_chz = 64'd32963;
      NOTA_F4:  f_chz = 64'd34923;
      NOTA_FS4: f_chz = 64'd36999;
      NOTA_G4:  f_chz = 64'd39200;
      NOTA_GS4: f_chz = 64'd41530;
      NOTA_A4:  f_chz = 64'd44000;
      NOTA_AS4: f_chz = 64'd46616;
      NOTA_B4:  f_chz = 64'd49388;
      default:  f_chz = 64'd0;
    endcase
    if (f_chz == 64'd0) begin
      q = 64'd0;
    end else begin
      q = (clk_hz * 64'd50 + (f_chz >> 1)) / f_chz;
      if (q == 64'd0) begin
        q = 64'd1;
      end else if (q > 64'd65535) begin
        q = 64'd65535;
      end else begin
        q = q;
      end
    end
    return q[15:0];
  endfunction

endpackage

// File: rtl/divisor_tono.sv
// divisor_tono
// Phase counter and square-wave toggle for one note.
// Ports:
//   clk           in   system clock (rising edge)
//   rst           in   synchronous active-high reset
//   habilitar     in   1 = run the counter; 0 = clear counter and force onda low
//   medio_periodo in   half-period H in cycles (counter runs 0..H-1)
//   onda          out  registered square wave, toggles when the counter hits H-1
module divisor_tono (
  input  logic        clk,
  input  logic        rst,
  input  logic        habilitar,
  input  logic [15:0] medio_periodo,
  output logic        onda
);

  logic [15:0] r_cuenta;
  logic        r_onda;
  logic        w_ultimo;

  // ">=" rather than "==" so a counter already past H-1 still wraps; H = 0
  // is treated like H = 1 (toggle every cycle).
  assign w_ultimo = (medio_periodo == 16'd0) || (r_cuenta >= (medio_periodo - 16'd1));

  // Phase counter with toggle on the last count; disabled means silent and cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cuenta <= 16'd0;
      r_onda   <= 1'b0;
    end else if (!habilitar) begin
      r_cuenta <= 16'd0;
      r_onda   <= 1'b0;
    end else if (w_ultimo) begin
      r_cuenta <= 16'd0;
      r_onda   <= ~r_onda;
    end else begin
      r_cuenta <= r_cuenta + 16'd1;
    end
  end

  assign onda = r_onda;

endmodule

// File: rtl/reproductor_nota.sv
// reproductor_nota
// Plays one note of the song ROM per slot as a 50%-duty square wave.
// Parameters:
//   CLK_HZ          system clock frequency, drives the pitch table
//   TICKS_NOTA      cycles per note slot
//   TICKS_SILENCIO  silent articulation gap at the end of each slot (< TICKS_NOTA)
// Ports:
//   clk             in   system clock (rising edge)
//   rst             in   synchronous active-high reset
//   direccion_nota  in   song step 0..24 from the sequencer (>24 = rest)
//   audio_out       out  square-wave audio
//   nota_activa     out  high while a pitched note is in PLAY
//   codigo_nota     out  note code currently latched
module reproductor_nota #(
  parameter int unsigned CLK_HZ         = 32'd12000000,
  parameter int unsigned TICKS_NOTA     = 32'd6000000,
  parameter int unsigned TICKS_SILENCIO = 32'd600000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] direccion_nota,
  output logic       audio_out,
  output logic       nota_activa,
  output logic [3:0] codigo_nota
);

  import pkg_musica::*;

  // The timer value equals the cycle index within the slot: PLAY covers
  // 0..N-S-1, GAP covers N-S..N-1.
  localparam logic [22:0] FIN_PLAY = 23'(TICKS_NOTA - TICKS_SILENCIO - 32'd1);
  localparam logic [22:0] FIN_NOTA = 23'(TICKS_NOTA - 32'd1);
  localparam logic        HAY_GAP  = (TICKS_SILENCIO != 32'd0);

  estado_t     r_estado;
  logic [4:0]  r_dir_prev;
  logic        r_pendiente;
  logic [3:0]  r_rom;
  logic [3:0]  r_codigo;
  logic [15:0] r_h;
  logic [22:0] r_timer;
  logic        r_activa;

  logic        w_cambio;
  logic        w_dir_valida;
  logic        w_fin_play;
  logic        w_fin_nota;
  logic        w_habilitar;
  logic        w_onda;
  logic [15:0] w_tabla_h [16];

  // Pitch table folded at elaboration from CLK_HZ; indexed by the ROM code.
  genvar g;
  for (g = 0; g < 16; g++) begin : g_tabla
    localparam logic [15:0] H_CODIGO = calc_medio_periodo(64'(CLK_HZ), 4'(g));
    assign w_tabla_h[g] = H_CODIGO;
  end

  assign w_cambio     = r_pendiente || (direccion_nota != r_dir_prev);
  assign w_dir_valida = (direccion_nota <= DIR_MAX);
  assign w_fin_play   = (r_timer == FIN_PLAY);
  assign w_fin_nota   = (r_timer == FIN_NOTA);

  // Enable only for cycles that stay in PLAY; leaving PLAY on this edge
  // (preemption or slot end) silences the output on that same edge.
  assign w_habilitar = (r_estado == ST_PLAY) && es_tono(r_codigo) && !w_cambio && !w_fin_play;

  // Change detector and registered ROM read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dir_prev  <= 5'd0;
      r_pendiente <= 1'b1;
      r_rom       <= NOTA_SILENCIO;
    end else begin
      r_dir_prev  <= direccion_nota;
      // A change landing during FETCH would otherwise be lost because FETCH
      // latches the previous ROM word; keep it pending for the PLAY cycle.
      r_pendiente <= (r_estado == ST_FETCH) && w_cambio;
      r_rom       <= w_dir_valida ? nota_cancion(direccion_nota) : NOTA_SILENCIO;
    end
  end

  // Note FSM with slot timer and registered note outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado <= ST_IDLE;
      r_timer  <= 23'd0;
      r_codigo <= NOTA_SILENCIO;
      r_h      <= 16'd0;
      r_activa <= 1'b0;
    end else begin
      case (r_estado)
        ST_IDLE: begin
          r_timer  <= 23'd0;
          r_activa <= 1'b0;
          if (w_cambio) begin
            r_estado <= ST_FETCH;
          end else begin
            r_estado <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          r_codigo <= r_rom;
          r_h      <= w_tabla_h[r_rom];
          r_timer  <= 23'd0;
          r_activa <= es_tono(r_rom);
          r_estado <= ST_PLAY;
        end
        ST_PLAY: begin
          if (w_cambio) begin
            r_estado <= ST_FETCH;
            r_timer  <= 23'd0;
            r_activa <= 1'b0;
          end else if (w_fin_play) begin
            r_estado <= HAY_GAP ? ST_GAP : ST_IDLE;
            r_timer  <= HAY_GAP ? (r_timer + 23'd1) : 23'd0;
            r_activa <= 1'b0;
          end else begin
            r_timer  <= r_timer + 23'd1;
          end
        end
        ST_GAP: begin
          r_activa <= 1'b0;
          if (w_cambio) begin
            r_estado <= ST_FETCH;
            r_timer  <= 23'd0;
          end else if (w_fin_nota) begin
            r_estado <= ST_IDLE;
            r_timer  <= 23'd0;
          end else begin
            r_timer  <= r_timer + 23'd1;
          end
        end
        default: begin
          r_estado <= ST_IDLE;
          r_timer  <= 23'd0;
          r_activa <= 1'b0;
        end
      endcase
    end
  end

  divisor_tono u_divisor (
    .clk           (clk),
    .rst           (rst),
    .habilitar     (w_habilitar),
    .medio_periodo (r_h),
    .onda          (w_onda)
  );

  assign audio_out   = w_onda;
  assign nota_activa = r_activa;
  assign codigo_nota = r_codigo;

endmodule

// File: tb/tb_reproductor_nota.sv
module tb_reproductor_nota;

  // Scaled-down clock so each slot is short; pitch values re-derived:
  //   A4: round(1200000 / (2*440.00)) = round(1363.64) = 1364
  //   C4: round(1200000 / (2*261.63)) = round(2293.31) = 2293
  localparam int unsigned CLK_HZ         = 1200000;
  localparam int unsigned TICKS_NOTA     = 8000;
  localparam int unsigned TICKS_SILENCIO = 800;
  localparam int unsigned H_A4           = 1364;
  localparam int unsigned H_C4           = 2293;
  localparam int unsigned PLAY_LEN       = TICKS_NOTA - TICKS_SILENCIO;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] direccion_nota = 5'd0;
  logic       audio_out;
  logic       nota_activa;
  logic [3:0] codigo_nota;

  typedef struct {
    int unsigned cyc;
    logic        audio;
    logic        activa;
    logic [3:0]  codigo;
    int          id;
  } esp_t;

  esp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;

  reproductor_nota #(
    .CLK_HZ         (CLK_HZ),
    .TICKS_NOTA     (TICKS_NOTA),
    .TICKS_SILENCIO (TICKS_SILENCIO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .direccion_nota (direccion_nota),
    .audio_out      (audio_out),
    .nota_activa    (nota_activa),
    .codigo_nota    (codigo_nota)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void esperar(int unsigned c, logic a, logic act, logic [3:0] cod, int id);
    esp_t e;
    e.cyc = c; e.audio = a; e.activa = act; e.codigo = cod; e.id = id;
    sb.push_back(e);
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({audio_out, nota_activa, codigo_nota} !== {1'b0, 1'b0, 4'd0}) begin
        failures++;
        $display("FAIL reset[%0d] got audio=%b activa=%b codigo=%0d expected 0 0 0",
                 i, audio_out, nota_activa, codigo_nota);
      end
      direccion_nota = 5'($urandom_range(0, 24));
    end
  endtask

  // Step 3 = A4 from reset release: latency, period, gap boundary, no restart.
  task automatic test_a4();
    int unsigned t0;
    esp_t e;
    @(negedge clk);
    t0 = cyc;
    rst = 1'b0;
    direccion_nota = 5'd3;
    esperar(t0 + 1, 1'b0, 1'b0, 4'd0, 1);
    esperar(t0 + 2, 1'b0, 1'b1, 4'd10, 2);
    esperar(t0 + 1 + H_A4, 1'b0, 1'b1, 4'd10, 3);
    esperar(t0 + 2 + H_A4, 1'b1, 1'b1, 4'd10, 4);
    esperar(t0 + 1 + 2*H_A4, 1'b1, 1'b1, 4'd10, 5);
    esperar(t0 + 2 + 2*H_A4, 1'b0, 1'b1, 4'd10, 6);
    esperar(t0 + 2 + 3*H_A4, 1'b1, 1'b1, 4'd10, 7);
    esperar(t0 + 1 + PLAY_LEN, 1'b1, 1'b1, 4'd10, 8);
    esperar(t0 + 2 + PLAY_LEN, 1'b0, 1'b0, 4'd10, 9);
    esperar(t0 + 8500, 1'b0, 1'b0, 4'd10, 10);
    for (int i = 0; i < 9000; i++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if ({audio_out, nota_activa, codigo_nota} !== {e.audio, e.activa, e.codigo}) begin
          failures++;
          $display("FAIL a4[%0d] cyc=%0d got audio=%b activa=%b codigo=%0d expected audio=%b activa=%b codigo=%0d",
                   e.id, cyc - t0, audio_out, nota_activa, codigo_nota, e.audio, e.activa, e.codigo);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL a4_pending got %0d unchecked expected 0", sb.size());
      sb.delete();
    end
  endtask

  // A rest slot (ROM zero or out-of-range step) stays silent for the whole slot.
  task automatic test_rest(input logic [4:0] dir_in, input logic [3:0] cod_antes);
    int unsigned t0;
    int          ruido;
    esp_t        e;
    ruido = 0;
    @(negedge clk);
    t0 = cyc;
    direccion_nota = dir_in;
    esperar(t0 + 1, 1'b0, 1'b0, cod_antes, 1);
    esperar(t0 + 2, 1'b0, 1'b0, 4'd0, 2);
    esperar(t0 + TICKS_NOTA + 5, 1'b0, 1'b0, 4'd0, 3);
    for (int i = 0; i < TICKS_NOTA + 100; i++) begin
      @(negedge clk);
      if (audio_out !== 1'b0 || nota_activa !== 1'b0) ruido++;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if ({audio_out, nota_activa, codigo_nota} !== {e.audio, e.activa, e.codigo}) begin
          failures++;
          $display("FAIL rest%0d[%0d] cyc=%0d got audio=%b activa=%b codigo=%0d expected audio=%b activa=%b codigo=%0d",
                   dir_in, e.id, cyc - t0, audio_out, nota_activa, codigo_nota, e.audio, e.activa, e.codigo);
        end
      end
    end
    checks++;
    if (ruido != 0) begin
      failures++;
      $display("FAIL rest%0d_silent got %0d noisy cycles expected 0", dir_in, ruido);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL rest_pending got %0d unchecked expected 0", sb.size());
      sb.delete();
    end
  endtask

  // A4 preempted mid-note by step 4 (C4): FETCH, silence, new pitch, timer restarted.
  task automatic test_preempt();
    int unsigned t0, t1;
    esp_t e;
    @(negedge clk);
    t0 = cyc;
    t1 = t0 + 4500;
    direccion_nota = 5'd3;
    esperar(t0 + 1, 1'b0, 1'b0, 4'd0, 1);
    esperar(t0 + 2, 1'b0, 1'b1, 4'd10, 2);
    esperar(t1, 1'b1, 1'b1, 4'd10, 3);
    esperar(t1 + 1, 1'b0, 1'b0, 4'd10, 4);
    esperar(t1 + 2, 1'b0, 1'b1, 4'd1, 5);
    esperar(t1 + 1 + H_C4, 1'b0, 1'b1, 4'd1, 6);
    esperar(t1 + 2 + H_C4, 1'b1, 1'b1, 4'd1, 7);
    esperar(t1 + 2 + 2*H_C4, 1'b0, 1'b1, 4'd1, 8);
    esperar(t1 + 1 + PLAY_LEN, 1'b1, 1'b1, 4'd1, 9);
    esperar(t1 + 2 + PLAY_LEN, 1'b0, 1'b0, 4'd1, 10);
    for (int i = 0; i < 4500 + 7300; i++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if ({audio_out, nota_activa, codigo_nota} !== {e.audio, e.activa, e.codigo}) begin
          failures++;
          $display("FAIL preempt[%0d] cyc=%0d got audio=%b activa=%b codigo=%0d expected audio=%b activa=%b codigo=%0d",
                   e.id, cyc - t0, audio_out, nota_activa, codigo_nota, e.audio, e.activa, e.codigo);
        end
      end
      if (cyc == t1) direccion_nota = 5'd4;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL preempt_pending got %0d unchecked expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Step 24 then wrap to step 0 (C4): change detected, normal latency.
  task automatic test_wrap();
    int unsigned t0, t1;
    esp_t e;
    @(negedge clk);
    t0 = cyc;
    t1 = t0 + 3000;
    direccion_nota = 5'd24;
    esperar(t0 + 1, 1'b0, 1'b0, 4'd1, 1);
    esperar(t0 + 2, 1'b0, 1'b1, 4'd10, 2);
    esperar(t0 + 2 + H_A4, 1'b1, 1'b1, 4'd10, 3);
    esperar(t1, 1'b0, 1'b1, 4'd10, 4);
    esperar(t1 + 1, 1'b0, 1'b0, 4'd10, 5);
    esperar(t1 + 2, 1'b0, 1'b1, 4'd1, 6);
    esperar(t1 + 1 + H_C4, 1'b0, 1'b1, 4'd1, 7);
    esperar(t1 + 2 + H_C4, 1'b1, 1'b1, 4'd1, 8);
    for (int i = 0; i < 3000 + H_C4 + 20; i++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if ({audio_out, nota_activa, codigo_nota} !== {e.audio, e.activa, e.codigo}) begin
          failures++;
          $display("FAIL wrap[%0d] cyc=%0d got audio=%b activa=%b codigo=%0d expected audio=%b activa=%b codigo=%0d",
                   e.id, cyc - t0, audio_out, nota_activa, codigo_nota, e.audio, e.activa, e.codigo);
        end
      end
      if (cyc == t1) direccion_nota = 5'd0;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL wrap_pending got %0d unchecked expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Reset while A4 is high: silent on the next edge, then replays from FETCH.
  task automatic test_mid_reset();
    int unsigned t0, t1;
    esp_t e;
    @(negedge clk);
    t0 = cyc;
    t1 = t0 + 4500;
    direccion_nota = 5'd3;
    esperar(t0 + 1, 1'b0, 1'b0, 4'd1, 1);
    esperar(t0 + 2, 1'b0, 1'b1, 4'd10, 2);
    esperar(t1, 1'b1, 1'b1, 4'd10, 3);
    esperar(t1 + 1, 1'b0, 1'b0, 4'd0, 4);
    esperar(t1 + 3, 1'b0, 1'b0, 4'd0, 5);
    esperar(t1 + 4, 1'b0, 1'b0, 4'd0, 6);
    esperar(t1 + 5, 1'b0, 1'b1, 4'd10, 7);
    esperar(t1 + 4 + H_A4, 1'b0, 1'b1, 4'd10, 8);
    esperar(t1 + 5 + H_A4, 1'b1, 1'b1, 4'd10, 9);
    for (int i = 0; i < 4500 + H_A4 + 20; i++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if ({audio_out, nota_activa, codigo_nota} !== {e.audio, e.activa, e.codigo}) begin
          failures++;
          $display("FAIL mid_reset[%0d] cyc=%0d got audio=%b activa=%b codigo=%0d expected audio=%b activa=%b codigo=%0d",
                   e.id, cyc - t0, audio_out, nota_activa, codigo_nota, e.audio, e.activa, e.codigo);
        end
      end
      if (cyc == t1) rst = 1'b1;
      if (cyc == t1 + 3) rst = 1'b0;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL mid_reset_pending got %0d unchecked expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_a4();
    test_rest(5'd5, 4'd10);
    test_rest(5'd30, 4'd0);
    test_preempt();
    test_wrap();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
